// File: rtl/const_seq_if.sv
// Output stream interface for const_seq: valid/ready word stream plus restart and done.
interface const_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             restart;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             done;

    modport master (
        input  restart,
        input  out_ready,
        output out_valid,
        output out,
        output done
    );

    modport slave (
        output restart,
        output out_ready,
        input  out_valid,
        input  out,
        input  done
    );
endinterface

// File: rtl/const_seq.sv
// Constant-sequence generator for the CGRA constant PE slot; scan-configured via the config chain.
// Optional macro CONST_SEQ_ACCUM_EN turns MODE 3 into an accumulating RAMP; otherwise MODE 3 is STATIC.
module const_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          Config_Clock,
    input  logic          Config_Reset,
    input  logic          Config_Enable,
    input  logic          ConfigIn,
    output logic          ConfigOut,
    const_seq_if.master   io
);
    localparam int unsigned IW       = $clog2(DEPTH);
    localparam int unsigned N        = DEPTH * WIDTH + IW + 2;
    localparam int unsigned LAST_LSB = DEPTH * WIDTH;
    localparam int unsigned MODE_LSB = LAST_LSB + IW;

    localparam logic [1:0] MODE_STATIC  = 2'd0;
    localparam logic [1:0] MODE_CYCLE   = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_RAMP    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [N-1:0]     r_chain;
    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic             r_valid;
    logic             r_done;

    logic [WIDTH-1:0] w_entry [DEPTH];
    logic [IW-1:0]    w_last_raw;
    logic [IW-1:0]    w_last;
    logic [1:0]       w_mode;
    logic             w_xfer;
    logic             w_cycle;
    logic             w_oneshot;

    // Bit-serial config chain, LSB is the first bit shifted in and the first bit out
    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            r_chain <= '0;
        end else if (Config_Enable) begin
            r_chain <= {ConfigIn, r_chain[N-1:1]};
        end
    end

    assign ConfigOut = r_chain[0];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_entry[g] = r_chain[g*WIDTH +: WIDTH];
    end

    assign w_last_raw = r_chain[LAST_LSB +: IW];
    assign w_last     = (w_last_raw > IW'(DEPTH - 1)) ? IW'(DEPTH - 1) : w_last_raw;
    assign w_mode     = r_chain[MODE_LSB +: 2];
    assign w_cycle    = (w_mode == MODE_CYCLE);
    assign w_oneshot  = (w_mode == MODE_ONESHOT);
    assign w_xfer     = r_valid & io.out_ready;

`ifdef CONST_SEQ_ACCUM_EN
    logic [WIDTH-1:0] r_acc;
    logic             w_ramp;

    assign w_ramp = (w_mode == MODE_RAMP);
    assign io.out = w_ramp ? r_acc : w_entry[r_idx];
`else
    // Without the accumulator, MODE 3 falls through to STATIC (idx never advances)
    assign io.out = w_entry[r_idx];
`endif

    assign io.out_valid = r_valid;
    assign io.done      = r_done;

    // Sequencer FSM; config shifting always forces IDLE and aborts any sequence
    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
`ifdef CONST_SEQ_ACCUM_EN
            r_acc   <= '0;
`endif
        end else if (Config_Enable) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                    r_idx   <= '0;
                    r_valid <= 1'b1;
`ifdef CONST_SEQ_ACCUM_EN
                    r_acc   <= w_entry[0];
`endif
                end
                S_RUN: begin
                    // restart wins over a simultaneous transfer: word consumed, no advance
                    if (io.restart) begin
                        r_idx <= '0;
`ifdef CONST_SEQ_ACCUM_EN
                        r_acc <= w_entry[0];
`endif
                    end else if (w_xfer) begin
                        if (w_cycle) begin
                            r_idx <= (r_idx == w_last) ? '0 : r_idx + IW'(1);
                        end else if (w_oneshot) begin
                            if (r_idx == w_last) begin
                                r_state <= S_DONE;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx <= r_idx + IW'(1);
                            end
                        end
`ifdef CONST_SEQ_ACCUM_EN
                        else if (w_ramp) begin
                            r_acc <= r_acc + w_entry[1];
                        end
`endif
                    end
                end
                S_DONE: begin
                    // idx stays at LAST so out shows the final entry
                    if (io.restart) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_done  <= 1'b0;
`ifdef CONST_SEQ_ACCUM_EN
                        r_acc   <= w_entry[0];
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // MODE_STATIC and MODE_RAMP are decoded by exclusion; names kept for readability
    logic w_unused_modes;
    assign w_unused_modes = ^{MODE_STATIC, MODE_RAMP};

endmodule

// File: tb/tb_const_seq.sv
// Directed self-checking bench for const_seq (WIDTH=32, DEPTH=4, N=132).
module tb_const_seq;
    localparam int unsigned N = 132;

    logic Config_Clock  = 1'b0;
    logic Config_Reset  = 1'b0;
    logic Config_Enable = 1'b0;
    logic ConfigIn      = 1'b0;
    logic ConfigOut;

    const_seq_if #(.WIDTH(32)) bus ();

    const_seq #(.WIDTH(32), .DEPTH(4)) dut (
        .Config_Clock  (Config_Clock),
        .Config_Reset  (Config_Reset),
        .Config_Enable (Config_Enable),
        .ConfigIn      (ConfigIn),
        .ConfigOut     (ConfigOut),
        .io            (bus)
    );

    initial forever #5 Config_Clock = ~Config_Clock;

    int n_chk  = 0;
    int n_fail = 0;
    logic [N-1:0] cfg_vec;
    logic [N-1:0] cap;

    task automatic tick();
        @(posedge Config_Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic shift_cfg(input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3,
                             input int last, input int mode);
        cfg_vec = {mode[1:0], last[1:0], e3, e2, e1, e0};
        for (int i = 0; i < int'(N); i++) begin
            Config_Enable = 1'b1;
            ConfigIn      = cfg_vec[i];
            tick();
        end
        Config_Enable = 1'b0;
        ConfigIn      = 1'b0;
    endtask

    logic        rdy3 [5];
    logic [31:0] exp3 [5];
    logic [31:0] exp3b[5];
    logic [31:0] exp6 [4];

    initial begin
        rdy3  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp3  = '{32'd11, 32'd22, 32'd22, 32'd33, 32'd11};
        exp3b = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd11};
`ifdef CONST_SEQ_ACCUM_EN
        exp6  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
`else
        exp6  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
`endif
        bus.restart   = 1'b0;
        bus.out_ready = 1'b0;

        // reset values
        #12;
        chk("rst_out",       N'(bus.out),       N'(0));
        chk("rst_valid",     N'(bus.out_valid), N'(0));
        chk("rst_done",      N'(bus.done),      N'(0));
        chk("rst_configout", N'(ConfigOut),     N'(0));
        Config_Enable = 1'b1;
        Config_Reset  = 1'b1;
        tick();

        // static mode, then chain passthrough
        shift_cfg(32'd11, 32'd22, 32'd33, 32'd44, 3, 0);
        bus.out_ready = 1'b1;
        chk("t2_valid_pre", N'(bus.out_valid), N'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_valid", N'(bus.out_valid), N'(1));
            chk("t2_out",   N'(bus.out),       N'(32'd11));
            tick();
        end
        for (int i = 0; i < int'(N); i++) begin
            Config_Enable = 1'b1;
            ConfigIn      = 1'b0;
            cap[i]        = ConfigOut;
            tick();
        end
        Config_Enable = 1'b0;
        chk("t2_chain_replay", cap, cfg_vec);

        // asynchronous reset in the middle of a shift
        shift_cfg(32'd11, 32'd22, 32'd33, 32'd44, 3, 0);
        tick();
        chk("t1_pre_configout", N'(ConfigOut), N'(1));
        for (int i = 0; i < 3; i++) begin
            Config_Enable = 1'b1;
            ConfigIn      = 1'b1;
            tick();
        end
        #2;
        Config_Reset = 1'b0;
        #1;
        chk("t1_out",       N'(bus.out),       N'(0));
        chk("t1_valid",     N'(bus.out_valid), N'(0));
        chk("t1_configout", N'(ConfigOut),     N'(0));
        Config_Enable = 1'b0;
        ConfigIn      = 1'b0;
        #1;
        Config_Reset = 1'b1;
        tick();

        // cycle mode with LAST=2 and back-pressure
        shift_cfg(32'd11, 32'd22, 32'd33, 32'd44, 2, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.out_ready = rdy3[i];
            chk("t3_valid", N'(bus.out_valid), N'(1));
            chk("t3_out",   N'(bus.out),       N'(exp3[i]));
            tick();
        end
        // LAST=7 truncates/clamps to 3
        bus.out_ready = 1'b1;
        shift_cfg(32'd11, 32'd22, 32'd33, 32'd44, 7, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_last7_out", N'(bus.out), N'(exp3b[i]));
            tick();
        end

        // one-shot with LAST=1, then restarts
        shift_cfg(32'd11, 32'd22, 32'd33, 32'd44, 1, 2);
        tick();
        chk("t4_w0", N'(bus.out), N'(32'd11));
        tick();
        chk("t4_w1", N'(bus.out), N'(32'd22));
        tick();
        chk("t4_done_valid", N'(bus.out_valid), N'(0));
        chk("t4_done",       N'(bus.done),      N'(1));
        chk("t4_done_out",   N'(bus.out),       N'(32'd22));
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        chk("t4_rs_valid", N'(bus.out_valid), N'(1));
        chk("t4_rs_done",  N'(bus.done),      N'(0));
        chk("t4_rs_out",   N'(bus.out),       N'(32'd11));
        tick();
        chk("t4_idx1_out", N'(bus.out), N'(32'd22));
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        chk("t4_rsx_valid", N'(bus.out_valid), N'(1));
        chk("t4_rsx_out",   N'(bus.out),       N'(32'd11));

        // reconfiguration aborts a running cycle
        shift_cfg(32'd11, 32'd22, 32'd33, 32'd44, 3, 1);
        tick();
        tick();
        tick();
        chk("t5_idx2_out", N'(bus.out), N'(32'd33));
        Config_Enable = 1'b1;
        ConfigIn      = 1'b0;
        tick();
        chk("t5_abort_valid", N'(bus.out_valid), N'(0));
        chk("t5_abort_done",  N'(bus.done),      N'(0));
        shift_cfg(32'd5, 32'd6, 32'd7, 32'd8, 3, 1);
        tick();
        chk("t5_new_valid", N'(bus.out_valid), N'(1));
        chk("t5_new_out0",  N'(bus.out),       N'(32'd5));
        tick();
        chk("t5_new_out1",  N'(bus.out),       N'(32'd6));

        // mode 3: ramp with accumulator, else static
        shift_cfg(32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0, 0, 3);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t6_valid", N'(bus.out_valid), N'(1));
            chk("t6_out",   N'(bus.out),       N'(exp6[i]));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
